// File: rtl/count_step_ctrl.sv
// count_step_ctrl: debounced/auto-ticked 0..MOD-1 up/down counter with hold, wrap flag and 7-segment decode
module count_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TICK_CYCLES = 50_000_000,
  parameter int MOD = 8
) (
  input  logic        CLOCK_50,
  input  logic [17:0] SW,
  input  logic [3:0]  V_BT,
  output logic [0:6]  HEX4,
  output logic [1:0]  LEDG
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(TICK_CYCLES + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [3:0] LAST = 4'(MOD - 1);
  typedef enum logic [1:0] {IDLE, ARM, PRESSED, RELEASE} state_t;
  logic rst, auto_m, down, hold;
  logic meta_q, meta_d, btn_s_q, btn_s_d;
  state_t state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [3:0] count_q, count_d;
  logic wrap_q, wrap_d;
  logic press_pulse, tick, step, at_end;
  logic unused_ok;
  assign rst = SW[17];
  assign auto_m = SW[16];
  assign down = SW[15];
  assign hold = SW[14];
  assign unused_ok = ^{SW[13:0], V_BT[2:0]};
  always_comb begin
    meta_d = V_BT[3];
    btn_s_d = meta_q;
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = btn_s_q ? ARM : IDLE;
      ARM:     state_d = !btn_s_q ? IDLE : (dcnt_q == D_LAST ? PRESSED : ARM);
      PRESSED: state_d = btn_s_q ? PRESSED : RELEASE;
      RELEASE: state_d = btn_s_q ? PRESSED : (dcnt_q == D_LAST ? IDLE : RELEASE);
      default: state_d = IDLE;
    endcase
    press_pulse = state_q == ARM && state_d == PRESSED;
    dcnt_d = state_d != state_q ? '0 : (dcnt_q == D_LAST ? dcnt_q : dcnt_q + 1'b1);
    tick = auto_m && !hold && pcnt_q == P_LAST;
    pcnt_d = !auto_m ? '0 : hold ? pcnt_q : tick ? '0 : pcnt_q + 1'b1;
    step = hold ? 1'b0 : (auto_m ? tick : press_pulse);
    at_end = down ? count_q == 4'd0 : count_q == LAST;
    count_d = !step ? count_q : down ? (at_end ? LAST : count_q - 4'd1) : (at_end ? 4'd0 : count_q + 4'd1);
    wrap_d = step ? at_end : wrap_q;
  end
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      meta_q <= 1'b0;
      btn_s_q <= 1'b0;
      state_q <= IDLE;
      dcnt_q <= '0;
      pcnt_q <= '0;
      count_q <= 4'd0;
      wrap_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      btn_s_q <= btn_s_d;
      state_q <= state_d;
      dcnt_q <= dcnt_d;
      pcnt_q <= pcnt_d;
      count_q <= count_d;
      wrap_q <= wrap_d;
    end
  end
  always_comb begin
    HEX4 = 7'b1111111;
    case (count_q)
      4'd0: HEX4 = 7'b0000001;
      4'd1: HEX4 = 7'b1001111;
      4'd2: HEX4 = 7'b0010010;
      4'd3: HEX4 = 7'b0000110;
      4'd4: HEX4 = 7'b1001100;
      4'd5: HEX4 = 7'b0100100;
      4'd6: HEX4 = 7'b0100000;
      4'd7: HEX4 = 7'b0001111;
      4'd8: HEX4 = 7'b0000000;
      4'd9: HEX4 = 7'b0000100;
      default: HEX4 = 7'b1111111;
    endcase
  end
  assign LEDG = {wrap_q, state_q == PRESSED || state_q == RELEASE};
endmodule

// File: tb/tb_count_step_ctrl.sv
// tb_count_step_ctrl: scoreboard bench for count_step_ctrl with fast debounce/tick parameters
module tb_count_step_ctrl;
  logic clk = 1'b0;
  logic [17:0] sw;
  logic [3:0] v_bt;
  logic [0:6] hex4;
  logic [1:0] ledg;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct {
    logic [6:0] hex;
    logic wrap;
    int at;
  } exp_t;
  exp_t sb[$];
  int mcount = 0;
  logic mwrap = 1'b0;
  logic mdown = 1'b0;
  logic mon_en = 1'b0;
  logic [7:0] prev_out, cur_out;
  count_step_ctrl #(.DEBOUNCE_CYCLES(4), .TICK_CYCLES(5), .MOD(8)) dut (
    .CLOCK_50(clk),
    .SW(sw),
    .V_BT(v_bt),
    .HEX4(hex4),
    .LEDG(ledg)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic logic [6:0] seg(int n);
    case (n)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction
  task automatic check(string tag, int obs, int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  task automatic step_model(int at);
    logic w;
    w = mdown ? mcount == 0 : mcount == 7;
    mcount = mdown ? (w ? 7 : mcount - 1) : (w ? 0 : mcount + 1);
    mwrap = w;
    sb.push_back('{seg(mcount), w, at});
  endtask
  task automatic wait_n(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    if (mcount != 0 || mwrap) sb.push_back('{seg(0), 1'b0, cyc + 1});
    mcount = 0;
    mwrap = 1'b0;
    sw[17] = 1'b1;
    wait_n(2);
    sw[17] = 1'b0;
    wait_n(2);
  endtask
  task automatic press(int hold_c, int low_c, bit expect_step);
    if (expect_step) step_model(cyc + 7);
    v_bt[3] = 1'b1;
    wait_n(hold_c);
    v_bt[3] = 1'b0;
    wait_n(low_c);
  endtask
  always @(negedge clk) begin
    if (mon_en) begin
      cur_out = {hex4, ledg[1]};
      if (cur_out != prev_out) begin
        if (sb.size() == 0) check("unexpected_step", int'(cur_out), int'(prev_out));
        else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_hex", int'(hex4), int'(e.hex));
          check("sb_wrap", int'(ledg[1]), int'(e.wrap));
          if (e.at >= 0) check("sb_cycle", cyc, e.at);
        end
        prev_out = cur_out;
      end
    end
  end
  initial begin
    int e;
    sw = 18'h0;
    sw[17] = 1'b1;
    v_bt = 4'h0;
    wait_n(1);
    v_bt[3] = 1'b1;
    wait_n(1);
    v_bt[3] = 1'b0;
    wait_n(1);
    v_bt[3] = 1'b1;
    check("rst_hex", int'(hex4), int'(seg(0)));
    check("rst_ledg", int'(ledg), 0);
    v_bt[3] = 1'b0;
    wait_n(1);
    sw[17] = 1'b0;
    wait_n(4);
    check("post_rst_hex", int'(hex4), int'(seg(0)));
    check("post_rst_ledg", int'(ledg), 0);
    prev_out = {hex4, ledg[1]};
    mon_en = 1'b1;
    step_model(cyc + 7);
    v_bt[3] = 1'b1;
    wait_n(10);
    check("held_ledg0", int'(ledg[0]), 1);
    wait_n(10);
    v_bt[3] = 1'b0;
    wait_n(12);
    check("idle_ledg0", int'(ledg[0]), 0);
    for (int i = 0; i < 3; i++) begin
      v_bt[3] = 1'b1;
      wait_n(2);
      v_bt[3] = 1'b0;
      wait_n(2);
    end
    press(12, 12, 1'b1);
    press(3, 12, 1'b0);
    check("glitch_hex", int'(hex4), int'(seg(2)));
    do_reset();
    for (int i = 0; i < 9; i++) press(8, 10, 1'b1);
    do_reset();
    mdown = 1'b1;
    sw[15] = 1'b1;
    sw[16] = 1'b1;
    e = cyc;
    step_model(e + 5);
    step_model(e + 10);
    wait_n(12);
    sw[14] = 1'b1;
    v_bt[3] = 1'b1;
    wait_n(10);
    check("auto_btn_ledg0", int'(ledg[0]), 1);
    v_bt[3] = 1'b0;
    wait_n(12);
    check("hold_hex", int'(hex4), int'(seg(6)));
    step_model(cyc + 3);
    sw[14] = 1'b0;
    wait_n(3);
    sw[16] = 1'b0;
    wait_n(8);
    mdown = 1'b0;
    sw[15] = 1'b0;
    check("manual_hex", int'(hex4), int'(seg(5)));
    e = cyc;
    v_bt[3] = 1'b1;
    wait_n(5);
    mcount = 0;
    mwrap = 1'b0;
    sb.push_back('{seg(0), 1'b0, e + 6});
    sw[17] = 1'b1;
    wait_n(2);
    sw[17] = 1'b0;
    step_model(cyc + 7);
    wait_n(15);
    v_bt[3] = 1'b0;
    wait_n(12);
    check("final_hex", int'(hex4), int'(seg(1)));
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
